// File: rtl/exu_arbiter.sv
// Two-requester arbiter in front of one combinational exu.
// Each requester has a one-entry response buffer with valid/ready handout.
module exu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter bit RR     = 1'b1,
    parameter int MAX_OP = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] exu_a,
    output logic [DATA_W-1:0] exu_b,
    output logic [OP_W-1:0]   exu_op,
    input  logic [DATA_W-1:0] exu_result
);

    localparam logic [OP_W-1:0] MAX_OP_C = OP_W'(MAX_OP);

    logic              last_one;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              op_err;
    logic [DATA_W-1:0] cap_result;

    // A full buffer being drained this cycle may take a new op.
    assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready) && !rst;
    assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready) && !rst;

    assign grant0 = elig0 && (!elig1 || !RR || last_one);
    assign grant1 = elig1 && !grant0;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        exu_a  = '0;
        exu_b  = '0;
        exu_op = '0;
        unique case (1'b1)
            grant0: begin
                exu_a  = req0_a;
                exu_b  = req0_b;
                exu_op = req0_op;
            end
            grant1: begin
                exu_a  = req1_a;
                exu_b  = req1_b;
                exu_op = req1_op;
            end
            default: ;
        endcase
    end

    assign op_err     = exu_op > MAX_OP_C;
    assign cap_result = op_err ? '0 : exu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_err    <= 1'b0;
            last_one    <= 1'b1;
        end else begin
            if (grant0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= cap_result;
                rsp0_err    <= op_err;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (grant1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= cap_result;
                rsp1_err    <= op_err;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
            // Pointer remembers the most recent winner; idle cycles leave it.
            if (grant0) begin
                last_one <= 1'b0;
            end else if (grant1) begin
                last_one <= 1'b1;
            end
        end
    end

endmodule
